// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit counter + BTB predictor with mispredict detection and perf counters
module branch_predictor #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_target_i,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);
  localparam int N = 1 << IDX_W;
  logic [N-1:0]      valid;
  logic [TAG_W-1:0]  tag    [N];
  logic [XLEN-1:0]   target [N];
  logic [1:0]        ctr    [N];
  logic [IDX_W-1:0]  if_idx, upd_idx;
  logic [TAG_W-1:0]  if_tag, upd_tag;
  logic              upd_hit;
  assign if_idx  = if_pc_i[IDX_W+1:2];
  assign if_tag  = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_hit = valid[upd_idx] && (tag[upd_idx] == upd_tag);
  always_comb begin
    pred_taken_o  = valid[if_idx] && (tag[if_idx] == if_tag) && ctr[if_idx][1];
    pred_target_o = pred_taken_o ? target[if_idx] : if_pc_i + XLEN'(4);
    mispredict_o  = upd_valid_i && ((upd_taken_i != upd_pred_taken_i) ||
                    (upd_taken_i && upd_pred_taken_i && (upd_target_i != upd_pred_target_i)));
    redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
  end
  // Table lives in flops so the whole array can be cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid <= '0;
      for (int i = 0; i < N; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b01;
      end
    end else if (upd_valid_i) begin
      if (upd_hit && upd_taken_i) begin
        ctr[upd_idx]    <= (ctr[upd_idx] == 2'b11) ? 2'b11 : ctr[upd_idx] + 2'd1;
        target[upd_idx] <= upd_target_i;
      end else if (upd_hit) begin
        ctr[upd_idx]    <= (ctr[upd_idx] == 2'b00) ? 2'b00 : ctr[upd_idx] - 2'd1;
      end else if (upd_taken_i) begin
        valid[upd_idx]  <= 1'b1;
        tag[upd_idx]    <= upd_tag;
        target[upd_idx] <= upd_target_i;
        ctr[upd_idx]    <= 2'b10;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o <= '0;
      miss_cnt_o   <= '0;
    end else begin
      if (upd_valid_i && !(&branch_cnt_o)) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if (mispredict_o && !(&miss_cnt_o)) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed + randomized checks against a table-level reference model
module tb_branch_predictor;
  logic        clk = 0, rst = 1;
  logic [31:0] if_pc = 0, upd_pc = 0, upd_target = 0, upd_pred_target = 0;
  logic        upd_valid = 0, upd_taken = 0, upd_pred_taken = 0;
  logic        pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc;
  logic [3:0]  branch_cnt, miss_cnt;
  int total = 0, bad = 0;
  bit          mv   [64];
  int unsigned mtag [64];
  logic [31:0] mtgt [64];
  int          mc   [64];
  int          mb, mm;

  branch_predictor #(.XLEN(32), .IDX_W(6), .TAG_W(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .if_pc_i(if_pc), .pred_taken_o(pred_taken),
    .pred_target_o(pred_target), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
    .upd_taken_i(upd_taken), .upd_target_i(upd_target),
    .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
    .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
    .branch_cnt_o(branch_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned m_idx(logic [31:0] pc);
    return (pc / 4) % 64;
  endfunction

  function automatic int unsigned m_tagof(logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return mv[m_idx(pc)] && mtag[m_idx(pc)] == m_tagof(pc);
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && mc[m_idx(pc)] >= 2;
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_taken(pc) ? mtgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_miss();
    if (!upd_valid) return 0;
    if (upd_taken != upd_pred_taken) return 1;
    return upd_taken && upd_target != upd_pred_target;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mc[i] = 1;
    end
    mb = 0; mm = 0;
  endtask

  task automatic m_train();
    int unsigned i;
    if (!upd_valid) return;
    i = m_idx(upd_pc);
    if (mb < 15) mb++;
    if (m_miss() && mm < 15) mm++;
    if (m_hit(upd_pc)) begin
      if (upd_taken) begin
        if (mc[i] < 3) mc[i]++;
        mtgt[i] = upd_target;
      end else if (mc[i] > 0) mc[i]--;
    end else if (upd_taken) begin
      mv[i] = 1; mtag[i] = m_tagof(upd_pc); mtgt[i] = upd_target; mc[i] = 2;
    end
  endtask

  // Checks combinational outputs against the pre-edge model, then clocks and checks counters.
  task automatic cycle();
    #1;
    chk("pred_taken", 32'(pred_taken), 32'(m_taken(if_pc)));
    chk("pred_target", pred_target, m_target(if_pc));
    chk("mispredict", 32'(mispredict), 32'(m_miss()));
    chk("redirect", redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
    @(posedge clk);
    if (!rst) m_train();
    #1;
    chk("branch_cnt", 32'(branch_cnt), 32'(mb));
    chk("miss_cnt", 32'(miss_cnt), 32'(mm));
  endtask

  task automatic drive(logic [31:0] pc, logic tk, logic [31:0] tg, logic pt, logic [31:0] ptg);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg;
    upd_pred_taken = pt; upd_pred_target = ptg;
  endtask

  function automatic logic [31:0] rpc();
    if ($urandom % 8 == 0) return $urandom & 32'hFFFF_FFFC;
    return ((32'($urandom) % 4) << 8) | ((32'($urandom) % 8) << 2);
  endfunction

  initial begin
    m_reset();
    @(posedge clk); #1;
    if_pc = 32'h0; #1;
    chk("rst_taken0", 32'(pred_taken), 0); chk("rst_tgt0", pred_target, 32'h4);
    if_pc = 32'h40; #1;
    chk("rst_taken40", 32'(pred_taken), 0); chk("rst_tgt40", pred_target, 32'h44);
    if_pc = 32'hFFFF_FFFC; #1;
    chk("rst_takenFC", 32'(pred_taken), 0); chk("rst_tgtwrap", pred_target, 32'h0);
    chk("rst_bcnt", 32'(branch_cnt), 0); chk("rst_mcnt", 32'(miss_cnt), 0);
    rst = 0;
    @(posedge clk); #1;
    // allocate
    if_pc = 32'h40;
    drive(32'h40, 1, 32'h20, 0, 32'h44); #1;
    chk("alloc_misp", 32'(mispredict), 1); chk("alloc_redir", redirect_pc, 32'h20);
    cycle(); upd_valid = 0; #1;
    chk("alloc_taken", 32'(pred_taken), 1); chk("alloc_tgt", pred_target, 32'h20);
    chk("alloc_bcnt", 32'(branch_cnt), 1); chk("alloc_mcnt", 32'(miss_cnt), 1);
    // hysteresis
    drive(32'h40, 0, 32'h20, 1, 32'h20); cycle(); upd_valid = 0; #1;
    chk("hyst_nt", 32'(pred_taken), 0); chk("hyst_nt_tgt", pred_target, 32'h44);
    drive(32'h40, 1, 32'h20, 0, 32'h44); cycle();
    drive(32'h40, 1, 32'h20, 1, 32'h20); cycle();
    drive(32'h40, 0, 32'h20, 1, 32'h20); cycle(); upd_valid = 0; #1;
    chk("hyst_still_t", 32'(pred_taken), 1); chk("hyst_still_tgt", pred_target, 32'h20);
    // aliasing
    if_pc = 32'h140; #1;
    chk("alias_miss", 32'(pred_taken), 0); chk("alias_tgt", pred_target, 32'h144);
    drive(32'h140, 1, 32'h80, 0, 32'h144); cycle(); upd_valid = 0;
    if_pc = 32'h40; #1;
    chk("alias_evict", 32'(pred_taken), 0);
    if_pc = 32'h140; #1;
    chk("alias_new", 32'(pred_taken), 1); chk("alias_new_tgt", pred_target, 32'h80);
    // same-cycle lookup/update sees pre-update entry
    drive(32'h140, 0, 32'h80, 1, 32'h80); #1;
    chk("same_old", 32'(pred_taken), 1);
    cycle(); upd_valid = 0; #1;
    chk("same_new", 32'(pred_taken), 0);
    // target mismatch
    if_pc = 32'h40;
    drive(32'h40, 1, 32'h20, 0, 32'h44); cycle();
    drive(32'h40, 1, 32'h20, 1, 32'h24); #1;
    chk("tgt_misp", 32'(mispredict), 1); chk("tgt_redir", redirect_pc, 32'h20);
    cycle();
    // saturation
    for (int i = 0; i < 20; i++) begin
      drive(32'h200, 1, 32'h20, 0, 32'h0); cycle();
    end
    chk("sat_miss", 32'(miss_cnt), 15); chk("sat_branch", 32'(branch_cnt), 15);
    // async reset between edges; updates ignored while held
    upd_valid = 0; if_pc = 32'h200; #1;
    chk("pre_rst_taken", 32'(pred_taken), 1);
    #1 rst = 1; #1;
    m_reset();
    chk("async_taken", 32'(pred_taken), 0);
    chk("async_bcnt", 32'(branch_cnt), 0); chk("async_mcnt", 32'(miss_cnt), 0);
    if_pc = 32'h300;
    drive(32'h300, 1, 32'h20, 0, 32'h0);
    @(posedge clk); #1;
    chk("rst_ignore", 32'(pred_taken), 0); chk("rst_ignore_cnt", 32'(branch_cnt), 0);
    rst = 0; upd_valid = 0;
    // randomized
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) begin
        rst = 1; #1; m_reset(); rst = 0;
      end
      if_pc = rpc();
      upd_pc = ($urandom % 4 == 0) ? if_pc : rpc();
      upd_valid = ($urandom % 4) != 0;
      upd_taken = $urandom % 2;
      upd_target = ($urandom % 4 == 0) ? 32'h20 : ($urandom & 32'hFFFF_FFFC);
      if ($urandom % 2) begin
        upd_pred_taken = m_taken(upd_pc); upd_pred_target = m_target(upd_pc);
      end else begin
        upd_pred_taken = $urandom % 2; upd_pred_target = $urandom & 32'hFFFF_FFFC;
      end
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
